// File: rtl/fft_mux_arbiter_pkg.sv
// Shared definitions for the FFT datapath mux arbiter: state encoding,
// requester count and the one-hot to binary select encoder.
package fft_mux_arbiter_pkg;

  localparam int NUM_REQ   = 4;
  localparam int SEL_WIDTH = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // OR-reduction encoder; only meaningful for one-hot or all-zero input.
  function automatic logic [SEL_WIDTH-1:0] onehot_to_bin(input logic [NUM_REQ-1:0] oh);
    logic [SEL_WIDTH-1:0] b;
    b = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) b = b | SEL_WIDTH'(i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fft_rr_pick.sv
// Combinational round-robin picker: first set request searching upward
// from (ptr+1) mod NUM_REQ, so the requester at ptr has lowest priority.
module fft_rr_pick
  import fft_mux_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req,
  input  logic [SEL_WIDTH-1:0] ptr,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 valid
);

  logic [SEL_WIDTH-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      // Offset NUM_REQ truncates to 0 and lands on ptr itself: searched last.
      idx = ptr + SEL_WIDTH'(i);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fft_mux_arbiter.sv
// Round-robin arbiter for the shared FFT datapath 4:1 input mux.
// Optional per-requester grant counters on GNT_CNT with FFT_MUX_ARB_STATS_EN.
module fft_mux_arbiter
  import fft_mux_arbiter_pkg::*;
#(
  parameter int BURST_LEN  = 8,
`ifdef FFT_MUX_ARB_STATS_EN
  parameter int STAT_WIDTH = 16,
`endif
  parameter int CNT_WIDTH  = 4
)(
  input  logic                      CLK,
  input  logic                      RSTn,
  input  logic                      EN,
  input  logic [NUM_REQ-1:0]        REQ,
  input  logic                      BEAT,
  input  logic                      LAST,
  output logic [NUM_REQ-1:0]        GNT,
  output logic [SEL_WIDTH-1:0]      SEL,
  output logic                      BUSY,
  output logic [CNT_WIDTH-1:0]      BEAT_CNT,
`ifdef FFT_MUX_ARB_STATS_EN
  output logic [NUM_REQ*STAT_WIDTH-1:0] GNT_CNT,
`endif
  output state_t                    DBG_STATE
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(BURST_LEN - 1);

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic [NUM_REQ-1:0]   pick_gnt;
  logic                 pick_valid;
  logic [SEL_WIDTH-1:0] pick_sel;
  logic                 rel_beat, rel_wd, rel_any, new_grant;

  fft_rr_pick u_pick (
    .req   (REQ),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  assign pick_sel = onehot_to_bin(pick_gnt);

  // Handshake: BEAT means one beat was accepted downstream this cycle (no
  // backpressure here); LAST is only meaningful when BEAT=1. Both are
  // ignored unless a grant is active.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    new_grant = 1'b0;
    rel_beat  = BEAT && (LAST || (cnt_q == CNT_LAST));
    rel_wd    = !BEAT && !REQ[sel_q];
    rel_any   = (state_q == ST_GRANT) && (rel_beat || rel_wd);

    case (state_q)
      ST_IDLE: begin
        if (EN && pick_valid) new_grant = 1'b1;
      end
      ST_GRANT: begin
        if (rel_any) begin
          cnt_d = '0;
          // ptr_q already holds the releasing winner, so it is searched last.
          if (EN && pick_valid) begin
            new_grant = 1'b1;
          end else begin
            state_d = ST_IDLE;
            gnt_d   = '0;
          end
        end else if (BEAT) begin
          cnt_d = cnt_q + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
      end
    endcase

    if (new_grant) begin
      state_d = ST_GRANT;
      gnt_d   = pick_gnt;
      sel_d   = pick_sel;
      ptr_d   = pick_sel;
      cnt_d   = '0;
    end
  end

  // SEL is left untouched on return to IDLE so the mux does not toggle.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_WIDTH'(NUM_REQ - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign GNT       = gnt_q;
  assign SEL       = sel_q;
  assign BUSY      = (state_q == ST_GRANT);
  assign BEAT_CNT  = cnt_q;
  assign DBG_STATE = state_q;

`ifdef FFT_MUX_ARB_STATS_EN
  logic [STAT_WIDTH-1:0] stat_q [NUM_REQ];

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (new_grant && pick_gnt[i]) stat_q[i] <= stat_q[i] + STAT_WIDTH'(1);
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign GNT_CNT[g*STAT_WIDTH +: STAT_WIDTH] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_fft_mux_arbiter.sv
// Self-checking bench for fft_mux_arbiter (default BURST_LEN=8); the stats
// scenario is compiled in with FFT_MUX_ARB_STATS_EN.
module tb_fft_mux_arbiter;
  import fft_mux_arbiter_pkg::*;

  logic       CLK;
  logic       RSTn;
  logic       EN;
  logic [3:0] REQ;
  logic       BEAT;
  logic       LAST;
  logic [3:0] GNT;
  logic [1:0] SEL;
  logic       BUSY;
  logic [3:0] BEAT_CNT;
  state_t     DBG_STATE;
`ifdef FFT_MUX_ARB_STATS_EN
  logic [63:0] GNT_CNT;
`endif

  int n_checks = 0;
  int n_errors = 0;
  logic [1:0] exp_q[$];

  fft_mux_arbiter dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .EN        (EN),
    .REQ       (REQ),
    .BEAT      (BEAT),
    .LAST      (LAST),
    .GNT       (GNT),
    .SEL       (SEL),
    .BUSY      (BUSY),
    .BEAT_CNT  (BEAT_CNT),
`ifdef FFT_MUX_ARB_STATS_EN
    .GNT_CNT   (GNT_CNT),
`endif
    .DBG_STATE (DBG_STATE)
  );

  // Clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  // Driver tasks: inputs change 1 time unit after the rising edge,
  // outputs are sampled at the same point.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    EN   = 1'b0;
    REQ  = 4'b0000;
    BEAT = 1'b0;
    LAST = 1'b0;
    tick();
    tick();
    RSTn = 1'b1;
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    EN   = 1'b0;
    REQ  = 4'b0000;
    BEAT = 1'b0;
    LAST = 1'b0;
    #2;
    n_checks++; if (GNT !== 4'b0000) begin n_errors++; $display("FAIL reset_gnt got %b want 0000", GNT); end
    n_checks++; if (SEL !== 2'b00) begin n_errors++; $display("FAIL reset_sel got %b want 00", SEL); end
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL reset_busy got %b want 0", BUSY); end
    n_checks++; if (BEAT_CNT !== 4'd0) begin n_errors++; $display("FAIL reset_cnt got %0d want 0", BEAT_CNT); end
    n_checks++; if (DBG_STATE !== ST_IDLE) begin n_errors++; $display("FAIL reset_state got %b want IDLE", DBG_STATE); end
    tick();
    RSTn = 1'b1;
    // Async reset in the middle of a burst to requester 2
    EN  = 1'b1;
    REQ = 4'b0100;
    tick();
    n_checks++; if (GNT !== 4'b0100) begin n_errors++; $display("FAIL mid_reset_pre_gnt got %b want 0100", GNT); end
    BEAT = 1'b1;
    tick();
    tick();
    n_checks++; if (BEAT_CNT !== 4'd2) begin n_errors++; $display("FAIL mid_reset_pre_cnt got %0d want 2", BEAT_CNT); end
    RSTn = 1'b0;
    #1;
    n_checks++; if (GNT !== 4'b0000) begin n_errors++; $display("FAIL mid_reset_gnt got %b want 0000", GNT); end
    n_checks++; if (SEL !== 2'b00) begin n_errors++; $display("FAIL mid_reset_sel got %b want 00", SEL); end
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL mid_reset_busy got %b want 0", BUSY); end
    n_checks++; if (BEAT_CNT !== 4'd0) begin n_errors++; $display("FAIL mid_reset_cnt got %0d want 0", BEAT_CNT); end
    BEAT = 1'b0;
    REQ  = 4'b1111;
    #2;
    RSTn = 1'b1;
    tick();
    n_checks++; if (GNT !== 4'b0001) begin n_errors++; $display("FAIL post_reset_gnt got %b want 0001", GNT); end
  endtask

  task automatic test_fairness();
    logic [1:0] e;
    do_reset();
    EN  = 1'b1;
    REQ = 4'b1111;
    for (int k = 0; k < 5; k++) exp_q.push_back(2'(k % 4));
    tick();
    for (int k = 0; k < 5; k++) begin
      e = exp_q.pop_front();
      n_checks++; if (GNT !== (4'b0001 << e)) begin n_errors++; $display("FAIL fair_gnt[%0d] got %b want %b", k, GNT, 4'b0001 << e); end
      n_checks++; if (SEL !== e) begin n_errors++; $display("FAIL fair_sel[%0d] got %b want %b", k, SEL, e); end
      n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL fair_busy[%0d] got %b want 1", k, BUSY); end
      BEAT = 1'b1;
      LAST = 1'b1;
      if (k == 4) REQ = 4'b0000;
      tick();
    end
    BEAT = 1'b0;
    LAST = 1'b0;
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL fair_end_busy got %b want 0", BUSY); end
    n_checks++; if (exp_q.size() != 0) begin n_errors++; $display("FAIL fair_queue left %0d want 0", exp_q.size()); end
  endtask

  task automatic test_burst_cap();
    do_reset();
    EN  = 1'b1;
    REQ = 4'b0011;
    tick();
    BEAT = 1'b1;
    for (int b = 0; b < 8; b++) begin
      n_checks++; if (BEAT_CNT !== 4'(b)) begin n_errors++; $display("FAIL cap_cnt[%0d] got %0d want %0d", b, BEAT_CNT, b); end
      n_checks++; if (GNT !== 4'b0001) begin n_errors++; $display("FAIL cap_gnt[%0d] got %b want 0001", b, GNT); end
      tick();
    end
    n_checks++; if (GNT !== 4'b0010) begin n_errors++; $display("FAIL cap_next_gnt got %b want 0010", GNT); end
    n_checks++; if (BEAT_CNT !== 4'd0) begin n_errors++; $display("FAIL cap_next_cnt got %0d want 0", BEAT_CNT); end
    REQ  = 4'b0000;
    LAST = 1'b1;
    tick();
    BEAT = 1'b0;
    LAST = 1'b0;
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL cap_end_busy got %b want 0", BUSY); end
  endtask

  task automatic test_withdraw();
    logic [1:0] e;
    do_reset();
    EN  = 1'b1;
    REQ = 4'b0100;
    tick();
    n_checks++; if (GNT !== 4'b0100) begin n_errors++; $display("FAIL wd_gnt got %b want 0100", GNT); end
    n_checks++; if (SEL !== 2'b10) begin n_errors++; $display("FAIL wd_sel got %b want 10", SEL); end
    REQ = 4'b0000;
    tick();
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL wd_busy got %b want 0", BUSY); end
    n_checks++; if (GNT !== 4'b0000) begin n_errors++; $display("FAIL wd_idle_gnt got %b want 0000", GNT); end
    tick();
    n_checks++; if (SEL !== 2'b10) begin n_errors++; $display("FAIL wd_sel_hold got %b want 10", SEL); end
    REQ = 4'b1000;
    for (int k = 0; k < 4; k++) exp_q.push_back(2'd3);
    tick();
    for (int k = 0; k < 4; k++) begin
      e = exp_q.pop_front();
      n_checks++; if (GNT !== (4'b0001 << e)) begin n_errors++; $display("FAIL sole_gnt[%0d] got %b want %b", k, GNT, 4'b0001 << e); end
      n_checks++; if (BUSY !== 1'b1) begin n_errors++; $display("FAIL sole_busy[%0d] got %b want 1", k, BUSY); end
      n_checks++; if (BEAT_CNT !== 4'd0) begin n_errors++; $display("FAIL sole_cnt[%0d] got %0d want 0", k, BEAT_CNT); end
      BEAT = 1'b1;
      LAST = 1'b1;
      if (k == 3) REQ = 4'b0000;
      tick();
    end
    BEAT = 1'b0;
    LAST = 1'b0;
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL sole_end_busy got %b want 0", BUSY); end
  endtask

  task automatic test_en_gating();
    do_reset();
    EN  = 1'b1;
    REQ = 4'b0011;
    tick();
    n_checks++; if (GNT !== 4'b0001) begin n_errors++; $display("FAIL en_gnt got %b want 0001", GNT); end
    EN   = 1'b0;
    BEAT = 1'b1;
    tick();
    n_checks++; if (GNT !== 4'b0001) begin n_errors++; $display("FAIL en_hold_gnt got %b want 0001", GNT); end
    n_checks++; if (BEAT_CNT !== 4'd1) begin n_errors++; $display("FAIL en_hold_cnt got %0d want 1", BEAT_CNT); end
    LAST = 1'b1;
    tick();
    n_checks++; if (GNT !== 4'b0000) begin n_errors++; $display("FAIL en_release_gnt got %b want 0000", GNT); end
    n_checks++; if (BUSY !== 1'b0) begin n_errors++; $display("FAIL en_release_busy got %b want 0", BUSY); end
    // BEAT/LAST keep toggling in IDLE with EN low: nothing may change
    for (int k = 0; k < 3; k++) begin
      BEAT = 1'($urandom_range(0, 1));
      LAST = 1'($urandom_range(0, 1));
      tick();
      n_checks++; if (GNT !== 4'b0000) begin n_errors++; $display("FAIL en_idle_gnt[%0d] got %b want 0000", k, GNT); end
      n_checks++; if (BEAT_CNT !== 4'd0) begin n_errors++; $display("FAIL en_idle_cnt[%0d] got %0d want 0", k, BEAT_CNT); end
    end
    BEAT = 1'b0;
    LAST = 1'b0;
    EN   = 1'b1;
    tick();
    n_checks++; if (GNT !== 4'b0010) begin n_errors++; $display("FAIL en_regrant_gnt got %b want 0010", GNT); end
    n_checks++; if (SEL !== 2'b01) begin n_errors++; $display("FAIL en_regrant_sel got %b want 01", SEL); end
  endtask

`ifdef FFT_MUX_ARB_STATS_EN
  task automatic test_stats();
    do_reset();
    n_checks++; if (GNT_CNT !== 64'd0) begin n_errors++; $display("FAIL stats_reset got %h want 0", GNT_CNT); end
    EN  = 1'b1;
    REQ = 4'b1111;
    tick();
    BEAT = 1'b1;
    LAST = 1'b1;
    repeat (19) tick();
    REQ = 4'b0000;
    tick();
    BEAT = 1'b0;
    LAST = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (GNT_CNT[i*16 +: 16] !== 16'd5) begin
        n_errors++;
        $display("FAIL stats_cnt[%0d] got %0d want 5", i, GNT_CNT[i*16 +: 16]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fairness();
    test_burst_cap();
    test_withdraw();
    test_en_gating();
`ifdef FFT_MUX_ARB_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
